// File: rtl/fxp_partial_accumulator.sv
// Accumulates a sequence of ROWS x COLS partial-product tiles into one saturated
// fixed-point result tile, with per-beat alignment shift and valid/ready on both sides.

module fxp_pacc_lane #(
    parameter int W2        = 16,
    parameter int ACC_WIDTH = 28,
    parameter int FRAC_BITS = 8
) (
    input  logic [W2-1:0]        term_i,
    input  logic                 shift_i,
    input  logic                 first_i,
    input  logic [ACC_WIDTH-1:0] acc_i,
    output logic [ACC_WIDTH-1:0] acc_next_o,
    output logic [W2-1:0]        clamp_o,
    output logic                 sat_o
);
    logic signed [ACC_WIDTH-1:0] ext, term;
    logic [ACC_WIDTH-W2:0]       hi;

    assign ext        = {{(ACC_WIDTH-W2){term_i[W2-1]}}, term_i};
    assign term       = shift_i ? (ext <<< FRAC_BITS) : ext;
    assign acc_next_o = first_i ? term : acc_i + term;

    // Result fits in W2 bits only when every bit above the result sign matches it.
    assign hi      = acc_next_o[ACC_WIDTH-1:W2-1];
    assign sat_o   = !((&hi) | ~(|hi));
    assign clamp_o = !sat_o ? acc_next_o[W2-1:0] :
                     acc_next_o[ACC_WIDTH-1] ? {1'b1, {(W2-1){1'b0}}} : {1'b0, {(W2-1){1'b1}}};
endmodule

module fxp_partial_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int FRAC_BITS = 8,
    parameter int ACC_WIDTH = 2*WIDTH+FRAC_BITS+4,
    parameter int CNT_W     = 4
) (
    input  logic                         clk,
    input  logic                         _reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ROWS*COLS*2*WIDTH-1:0] in_data,
    input  logic                         in_shift,
    input  logic                         in_first,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ROWS*COLS*2*WIDTH-1:0] out_data,
    output logic                         out_sat,
    output logic [CNT_W-1:0]             out_terms
);
    localparam int W2 = 2*WIDTH;
    localparam int N  = ROWS*COLS;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                       state_q;
    logic [N-1:0][ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [N-1:0][W2-1:0]         term_tile, clamp_d, out_data_q;
    logic [N-1:0]                 sat_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d, out_terms_q;
    logic                         in_ready_q, out_valid_q, out_sat_q;
    logic                         accept, first_eff;

    assign term_tile = in_data;
    assign accept    = in_valid & in_ready_q;
    // A beat arriving in IDLE always starts a fresh accumulation.
    assign first_eff = (state_q == IDLE) | in_first;
    assign cnt_d     = first_eff ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));

    for (genvar e = 0; e < N; e++) begin : g_lane
        fxp_pacc_lane #(.W2(W2), .ACC_WIDTH(ACC_WIDTH), .FRAC_BITS(FRAC_BITS)) u_lane (
            .term_i    (term_tile[e]),
            .shift_i   (in_shift),
            .first_i   (first_eff),
            .acc_i     (acc_q[e]),
            .acc_next_o(acc_d[e]),
            .clamp_o   (clamp_d[e]),
            .sat_o     (sat_d[e])
        );
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_terms_q <= '0;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (in_last) begin
                            state_q     <= OUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= clamp_d;
                            out_sat_q   <= |sat_d;
                            out_terms_q <= cnt_d;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_terms = out_terms_q;
endmodule
